// File: rtl/shift_arb_pkg.sv
// Shared definitions for the shift32 sequencer/arbiter.
//   - FSM state encodings (3 bits)
//   - requester index constants: EIS unit on port 0, ALU rotate/normalize on port 1
package shift_arb_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ISSUE   = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_RELEASE = 3'd3;
    localparam logic [2:0] ST_RESP    = 3'd4;

    localparam logic REQ_EIS = 1'b0;
    localparam logic REQ_ALU = 1'b1;

endpackage

// File: rtl/shift_arb_rr.sv
// rr_arb2: two-way round-robin picker.
//   req [1:0] : request levels
//   rr        : index of the requester granted last time
//   gnt       : winning requester index (only meaningful when any = 1)
//   any       : at least one request present
// A lone requester always wins; on a tie the requester that did not win
// last time is chosen.
module rr_arb2
    import shift_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       rr,
    output logic       gnt,
    output logic       any
);

    // NOTE: every output gets a value on every path through always_comb;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        any = |req;
        gnt = REQ_EIS;
        if (req == 2'b11) begin
            gnt = ~rr;
        end else if (req[REQ_ALU]) begin
            gnt = REQ_ALU;
        end
    end

endmodule

// File: rtl/shift_arb.sv
// shift_arb: shares one multi-cycle shift32 barrel shifter between the EIS
// unit (port 0) and the ALU rotate/normalize path (port 1).
//   clk, reset          : clock (rising edge), asynchronous active-low reset
//   req[1:0]            : request levels, held until the matching done pulse
//   req_in0/req_shift0  : port 0 operand and signed shift amount
//   req_in1/req_shift1  : port 1 operand and signed shift amount
//   done[1:0]           : one-cycle completion pulse per requester
//   err                 : pulses with done when the watchdog aborted the shift
//   res_out/res_last    : result and last shifted-out bit, valid with done
//   sh_ready/sh_in/sh_shift : request side of the shift32 handshake
//   sh_done/sh_out/sh_last  : response side of the shift32 handshake
// A zero shift amount bypasses the shifter entirely. The watchdog limits
// the time the shifter may take to raise sh_done to TIMEOUT cycles.
module shift_arb
    import shift_arb_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [31:0] req_in0,
    input  logic [5:0]  req_shift0,
    input  logic [31:0] req_in1,
    input  logic [5:0]  req_shift1,
    output logic [1:0]  done,
    output logic        err,
    output logic [31:0] res_out,
    output logic        res_last,
    output logic        sh_ready,
    output logic [31:0] sh_in,
    output logic [5:0]  sh_shift,
    input  logic        sh_done,
    input  logic [31:0] sh_out,
    input  logic        sh_last
);

    // Watchdog holds 0..TIMEOUT-1 while sh_ready is high; the last value
    // triggers the abort, so sh_ready stays high for exactly TIMEOUT cycles.
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

    logic [2:0]       state;
    logic             gnt;
    logic             rr;
    logic             abort;
    logic [CNT_W-1:0] wd;

    logic             win;
    logic             any;
    logic [31:0]      win_op;
    logic [5:0]       win_amt;
    logic             resp_ok;

    rr_arb2 u_rr (
        .req (req),
        .rr  (rr),
        .gnt (win),
        .any (any)
    );

    assign win_op  = (win == REQ_ALU) ? req_in1    : req_in0;
    assign win_amt = (win == REQ_ALU) ? req_shift1 : req_shift0;

    // The result is only handed back if the winner is still asking for it;
    // a withdrawn request has its result dropped without a pulse.
    assign resp_ok = (state == ST_RESP) && req[gnt];
    assign done    = resp_ok ? ((gnt == REQ_ALU) ? 2'b10 : 2'b01) : 2'b00;
    assign err     = resp_ok && abort;

    // NOTE: registers are updated with non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            gnt      <= REQ_EIS;
            rr       <= REQ_ALU;
            abort    <= 1'b0;
            wd       <= '0;
            sh_ready <= 1'b0;
            sh_in    <= '0;
            sh_shift <= '0;
            res_out  <= '0;
            res_last <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any) begin
                        gnt      <= win;
                        rr       <= win;
                        abort    <= 1'b0;
                        sh_in    <= win_op;
                        sh_shift <= win_amt;
                        if (win_amt == 6'd0) begin
                            res_out  <= win_op;
                            res_last <= 1'b0;
                            state    <= ST_RESP;
                        end else begin
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    sh_ready <= 1'b1;
                    wd       <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (sh_done) begin
                        res_out  <= sh_out;
                        res_last <= sh_last;
                        sh_ready <= 1'b0;
                        state    <= ST_RELEASE;
                    end else if (wd == WD_LAST) begin
                        sh_ready <= 1'b0;
                        abort    <= 1'b1;
                        res_out  <= '0;
                        res_last <= 1'b0;
                        state    <= ST_RELEASE;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    // A hung shifter never raised sh_done, so there is
                    // nothing to wait for on the abort path.
                    if (abort || !sh_done) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_arb.sv
// Self-checking bench for shift_arb with a behavioural shift32 stand-in.
module tb_shift_arb;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [31:0] req_in0 = '0;
    logic [5:0]  req_shift0 = '0;
    logic [31:0] req_in1 = '0;
    logic [5:0]  req_shift1 = '0;
    logic [1:0]  done;
    logic        err;
    logic [31:0] res_out;
    logic        res_last;
    logic        sh_ready;
    logic [31:0] sh_in;
    logic [5:0]  sh_shift;
    logic        sh_done = 1'b0;
    logic [31:0] sh_out = '0;
    logic        sh_last = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    // Shifter stand-in controls
    int sh_lat = 0;
    bit sh_hang = 1'b0;
    int sh_cnt = 0;

    shift_arb #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_in0    (req_in0),
        .req_shift0 (req_shift0),
        .req_in1    (req_in1),
        .req_shift1 (req_shift1),
        .done       (done),
        .err        (err),
        .res_out    (res_out),
        .res_last   (res_last),
        .sh_ready   (sh_ready),
        .sh_in      (sh_in),
        .sh_shift   (sh_shift),
        .sh_done    (sh_done),
        .sh_out     (sh_out),
        .sh_last    (sh_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // shift32 behaviour: positive = left, negative = right (logical);
    // returns {last shifted-out bit, result}.
    function automatic logic [32:0] shift_ref(input logic [31:0] v, input logic [5:0] a);
        int n;
        n = int'($signed(a));
        if (n > 0) return {v[32-n], v << n};
        if (n < 0) return {v[-n-1], v >> (-n)};
        return {1'b0, v};
    endfunction

    // Four-phase shifter: done rises sh_lat cycles after ready is seen,
    // falls once ready has dropped. sh_hang suppresses done entirely.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                sh_done = 1'b0;
                sh_cnt  = sh_lat;
            end else if (sh_done) begin
                if (!sh_ready) sh_done = 1'b0;
            end else if (sh_ready && !sh_hang) begin
                if (sh_cnt == 0) begin
                    {sh_last, sh_out} = shift_ref(sh_in, sh_shift);
                    sh_done = 1'b1;
                end else begin
                    sh_cnt--;
                end
            end else begin
                sh_cnt = sh_lat;
            end
        end
    end

    task automatic drive(input int p, input bit r, input logic [31:0] v, input logic [5:0] a);
        req[p] = r;
        if (p == 0) begin
            req_in0 = v; req_shift0 = a;
        end else begin
            req_in1 = v; req_shift1 = a;
        end
    endtask

    // One request on an idle arbiter, with the operand corrupted after grant.
    task automatic run_op(input string tag, input int p, input logic [31:0] v, input logic [5:0] a,
                          input int lat, input bit hang, input logic [31:0] exp_res, input logic exp_last);
        int rdy_first, rdy_cnt, done_c, exp_c;
        logic [1:0] d;
        logic e, l;
        logic [31:0] r, si;
        logic [5:0] ss;
        bit bypass;
        bypass = (a == 6'd0);
        sh_lat = lat;
        sh_hang = hang;
        rdy_first = -1; rdy_cnt = 0; done_c = -1;
        d = '0; e = 1'b0; l = 1'b0; r = '0; si = '0; ss = '0;
        @(posedge clk);
        #1;
        drive(p, 1'b1, v, a);
        for (int c = 0; c < 200 && done_c < 0; c++) begin
            @(negedge clk);
            if (sh_ready) begin
                rdy_cnt++;
                if (rdy_first < 0) begin
                    rdy_first = c; si = sh_in; ss = sh_shift;
                end
            end
            if (done != 2'b00) begin
                done_c = c; d = done; e = err; r = res_out; l = res_last;
            end else if (c == 1) begin
                drive(p, 1'b1, ~v, a ^ 6'd1);
            end
        end
        @(posedge clk);
        #1;
        drive(p, 1'b0, '0, '0);
        exp_c = bypass ? 1 : (hang ? TIMEOUT + 3 : lat + 4);
        check({tag, ":grant"}, d, (p == 0) ? 2'b01 : 2'b10);
        check({tag, ":err"}, e, hang && !bypass);
        check({tag, ":res"}, r, exp_res);
        check({tag, ":last"}, l, exp_last);
        check({tag, ":latency"}, done_c, exp_c);
        if (bypass) begin
            check({tag, ":ready_quiet"}, rdy_cnt, 0);
        end else begin
            check({tag, ":ready_rise"}, rdy_first, 2);
            check({tag, ":ready_len"}, rdy_cnt, hang ? TIMEOUT : lat + 1);
            check({tag, ":sh_in"}, si, v);
            check({tag, ":sh_shift"}, ss, a);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [32:0] x;
        logic [1:0]  seq_d [4];
        logic [31:0] seq_r [4];
        logic        seq_l [4];
        int k;
        bit got0, seen1;
        logic [31:0] r;
        logic l;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst:done", done, 2'b00);
        check("rst:err", err, 1'b0);
        check("rst:res_out", res_out, 32'h0);
        check("rst:res_last", res_last, 1'b0);
        check("rst:sh_ready", sh_ready, 1'b0);
        check("rst:sh_in", sh_in, 32'h0);
        check("rst:sh_shift", sh_shift, 6'h0);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        // Directed cases
        run_op("p0_shl4", 0, 32'h0000_0001, 6'd4, 2, 1'b0, 32'h0000_0010, 1'b0);
        run_op("p1_shr5", 1, 32'h0000_0010, 6'(-5), 1, 1'b0, 32'h0000_0000, 1'b1);
        run_op("p1_shr4", 1, 32'h0000_0010, 6'(-4), 0, 1'b0, 32'h0000_0001, 1'b0);
        run_op("p0_bypass", 0, 32'hdead_beef, 6'd0, 0, 1'b0, 32'hdead_beef, 1'b0);
        run_op("p1_shr32", 1, 32'h8000_0000, 6'b100000, 3, 1'b0, 32'h0000_0000, 1'b1);
        run_op("hang", 0, 32'h5555_aaaa, 6'd7, 0, 1'b1, 32'h0000_0000, 1'b0);
        x = shift_ref(32'h5555_aaaa, 6'd7);
        run_op("post_hang", 0, 32'h5555_aaaa, 6'd7, 1, 1'b0, x[31:0], x[32]);

        // Withdrawal during WAIT: no pulse for port 0, port 1 served next
        sh_lat = 6; sh_hang = 1'b0; got0 = 1'b0; seen1 = 1'b0; r = '0; l = 1'b0;
        @(posedge clk);
        #1;
        drive(0, 1'b1, 32'h0000_1234, 6'd3);
        for (int c = 0; c < 100 && !seen1; c++) begin
            @(negedge clk);
            if (done[0]) got0 = 1'b1;
            if (done[1]) begin
                seen1 = 1'b1; r = res_out; l = res_last;
            end
            if (c == 3) begin
                drive(0, 1'b0, '0, '0);
                drive(1, 1'b1, 32'h0000_00f8, 6'(-4));
            end
        end
        @(posedge clk);
        #1;
        drive(1, 1'b0, '0, '0);
        check("wdraw:no_done0", got0, 1'b0);
        check("wdraw:port1_served", seen1, 1'b1);
        check("wdraw:res", r, 32'h0000_000f);
        check("wdraw:last", l, 1'b1);

        // Reset mid-WAIT, then both requesters held from reset
        repeat (2) @(posedge clk);
        sh_hang = 1'b1;
        @(posedge clk);
        #1;
        drive(0, 1'b1, 32'h0000_cafe, 6'd2);
        repeat (5) @(negedge clk);
        check("rst_mid:ready_before", sh_ready, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("rst_mid:sh_ready", sh_ready, 1'b0);
        check("rst_mid:done", done, 2'b00);
        sh_hang = 1'b0; sh_lat = 1;
        drive(0, 1'b1, 32'hc000_0003, 6'd1);
        drive(1, 1'b1, 32'h8000_0001, 6'(-1));
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        k = 0;
        for (int c = 0; c < 400 && k < 4; c++) begin
            @(negedge clk);
            if (done != 2'b00) begin
                seq_d[k] = done; seq_r[k] = res_out; seq_l[k] = res_last;
                k++;
            end
        end
        @(posedge clk);
        #1;
        drive(0, 1'b0, '0, '0);
        drive(1, 1'b0, '0, '0);
        check("alt:count", k, 4);
        for (int i = 0; i < k; i++) begin
            check($sformatf("alt%0d:grant", i), seq_d[i], (i % 2 == 0) ? 2'b01 : 2'b10);
            check($sformatf("alt%0d:res", i), seq_r[i], (i % 2 == 0) ? 32'h8000_0006 : 32'h4000_0000);
            check($sformatf("alt%0d:last", i), seq_l[i], 1'b1);
        end
        repeat (2) @(posedge clk);

        // Randomized single requests against the reference shifter
        for (int i = 0; i < 30; i++) begin
            int p, lat;
            logic [31:0] v;
            logic [5:0] a;
            p = $urandom_range(0, 1);
            v = $urandom;
            a = 6'($urandom);
            if ($urandom_range(0, 7) == 0) a = 6'b100000;
            if ($urandom_range(0, 7) == 0) a = 6'd0;
            lat = $urandom_range(0, 3);
            x = shift_ref(v, a);
            run_op($sformatf("rnd%0d", i), p, v, a, lat, 1'b0, x[31:0], x[32]);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/shift_arb.md
Name: shift_arb

Overview:
- Sequencer/arbiter that shares the single shift32 multi-cycle barrel shifter between two requesters: the EIS unit (ASH/ASHC) on port 0 and the ALU rotate/normalize path on port 1.
- Arbitrates round-robin, latches operands and drives the shifter's ready/done four-phase handshake.
- Returns result and last-shifted-out bit to the winner.
- Includes a watchdog that aborts hung shifts.

Parameters:
- TIMEOUT, 64, cycles allowed between sh_ready rise and sh_done rise before abort.
- CNT_W, 7, width of the watchdog counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous reset, active-low (0 = reset)
- req  in  2  per-requester request level; held until matching done pulse
- req_in0  in  32  port 0 operand
- req_shift0  in  6  port 0 signed shift amount (positive = left, negative = right)
- req_in1  in  32  port 1 operand
- req_shift1  in  6  port 1 signed shift amount
- done  out  2  one-cycle completion pulse, per requester
- err  out  1  one-cycle pulse together with done on watchdog abort
- res_out  out  32  result, valid while done is nonzero
- res_last  out  1  last bit shifted out, valid while done is nonzero
- sh_ready  out  1  to shift32 ready
- sh_in  out  32  to shift32 in, latched operand
- sh_shift  out  6  to shift32 shift, latched amount
- sh_done  in  1  from shift32 done
- sh_out  in  32  from shift32 out
- sh_last  in  1  from shift32 last_bit

Behaviour:
Reset values:
- All outputs 0; state IDLE; rr pointer = 1, so port 0 wins the first tie.

States:
- IDLE
  - Sample req. If no request, stay.
  - Winner: the only requester, or on a tie the one not equal to rr.
  - At the edge: latch winner's operand/amount into sh_in/sh_shift; record gnt; set rr = gnt.
  - If the amount is 0, go to RESP with res_out = operand, res_last = 0 (bypass; shifter untouched).
  - Otherwise go to ISSUE.
- ISSUE
  - sh_ready = 1; watchdog cleared.
  - Go to WAIT next cycle.
- WAIT
  - sh_ready held 1; watchdog increments each cycle.
  - When sh_done = 1: capture sh_out/sh_last into res_out/res_last, drop sh_ready, go to RELEASE.
  - When the watchdog reaches TIMEOUT: drop sh_ready, set abort flag, res_out = 0, res_last = 0, go to RELEASE.
- RELEASE
  - sh_ready = 0; wait for sh_done = 0.
  - Abort path: go to RESP without waiting.
  - Then go to RESP.
- RESP
  - Pulse done[gnt] = 1 for exactly one cycle, only if req[gnt] is still 1. Otherwise the result is discarded silently.
  - err = abort flag.
  - Go to IDLE.

Latency:
- Request sampled in IDLE cycle N; sh_ready high from cycle N+2.
- done pulses 2 cycles after sh_done falls.
- Bypass: done pulse in cycle N+1.

Rules:
- sh_in/sh_shift are stable from ISSUE through RELEASE; operand changes by the requester after grant are ignored.
- Requester withdrawing req mid-operation:
  - The shift still completes the handshake.
  - The other requester is served next.
- Requester must drop req or re-present a new operand in the cycle after done. If req is still high in the next IDLE, it is treated as a new request.
- Async reset mid-operation: sh_ready and done drop immediately.
- Amount field: full 6-bit two's complement is passed through unaltered, including -32 (6'b100000).
- Only one outstanding shift; no queuing.

Decomposition:
- Shared package/header:
  - state encodings (IDLE, ISSUE, WAIT, RELEASE, RESP; 3 bits)
  - requester index constants (REQ_EIS = 0, REQ_ALU = 1)
- Natural sub-module: rr_arb2, a two-way round-robin picker (req, rr → gnt, any). Everything else stays in shift_arb.

Test Plan:
- Port 0: in = 32'h00000001, shift = 4, real shift32 attached → done = 2'b01 once; res_out = 32'h00000010; sh_ready high from N+2 until sh_done.
- Port 1: in = 32'h00000010, shift = -5 → res_out = 32'h00000000, res_last = 1. Then shift = -4 → res_out = 32'h00000001, res_last = 0.
- Both req asserted from reset with different operands → port 0 served first, then port 1. Hold both asserted continuously → grants strictly alternate 0, 1, 0, 1.
- Port 0: shift = 0, in = 32'hdeadbeef → done[0] at N+1; res_out = 32'hdeadbeef; sh_ready never rises.
- Stub shifter never asserts sh_done → after TIMEOUT = 64 cycles in WAIT, sh_ready drops, done[0] and err pulse together, res_out = 0. A following request is then serviced normally.
- Drop req[0] during WAIT; assert reset low mid-WAIT in a separate run:
  - Withdrawn case: no done pulse, then port 1 is served.
  - Reset case: sh_ready = 0 asynchronously; after reset release the first grant goes to port 0.
